// File: rtl/i2c_sensor_reader.sv
// i2c_sensor_reader: single-shot I2C master performing a 16-bit register read
// (address-write, register pointer, repeated START, address-read, two data bytes, STOP).
// SCL and SDA are open-drain: each *_oe output pulls its line low when 1.

module i2c_sensor_reader #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [15:0] data_out
);

  localparam int QW = $clog2(CLK_DIV + 1);
  // Reload value for each quarter, and the one-longer value used right after acceptance
  // so the first quarter starts on the cycle after the accepting edge.
  localparam logic [QW-1:0] Q_TOP = QW'(CLK_DIV - 1);
  localparam logic [QW-1:0] Q_ARM = QW'(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, START, WR_BYTE, WR_ACK, RSTART, RD_BYTE, RD_ACK, STOP
  } state_t;

  state_t          state;
  logic [QW-1:0]   qcnt;
  logic [1:0]      phase;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_sel;
  logic            rd_last;
  logic            nack;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q;
  logic [7:0]      tx_shift;
  logic [15:0]     rx_shift;

  // SCL pull-down for a given state and quarter. The repeated START first pulls SCL low so
  // the slave can drop its ACK and SDA can rise before SCL is released again.
  function automatic logic scl_low(state_t s, logic [1:0] ph);
    case (s)
      START:                            scl_low = ph[1];
      RSTART:                           scl_low = (ph == 2'd0) || (ph == 2'd3);
      STOP:                             scl_low = (ph == 2'd0);
      WR_BYTE, WR_ACK, RD_BYTE, RD_ACK: scl_low = !ph[1];
      default:                          scl_low = 1'b0;
    endcase
  endfunction

  // SDA pull-down for a given state and quarter; released during slave ACKs and read bits.
  function automatic logic sda_low(state_t s, logic [1:0] ph, logic tx_msb, logic last_rd);
    case (s)
      START:   sda_low = (ph != 2'd0);
      RSTART:  sda_low = ph[1];
      STOP:    sda_low = !ph[1];
      WR_BYTE: sda_low = !tx_msb;
      RD_ACK:  sda_low = !last_rd;
      default: sda_low = 1'b0;
    endcase
  endfunction

  // Transaction FSM: SCL updates on a quarter boundary, SDA one cycle later, so the two
  // open-drain outputs never toggle on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      qcnt     <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      byte_sel <= 2'd0;
      rd_last  <= 1'b0;
      nack     <= 1'b0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      tx_shift <= 8'd0;
      rx_shift <= 16'd0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      data_out <= 16'd0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          dev_q   <= dev_addr;
          reg_q   <= reg_addr;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          nack    <= 1'b0;
          rd_last <= 1'b0;
          phase   <= 2'd0;
          qcnt    <= Q_ARM;
          state   <= START;
        end
      end else begin
        if (qcnt == Q_TOP)
          sda_oe <= sda_low(state, phase, tx_shift[7], rd_last);
        if (phase == 2'd2 && qcnt == '0) begin
          if (state == WR_ACK && sda_i)
            nack <= 1'b1;
          if (state == RD_BYTE)
            rx_shift <= {rx_shift[14:0], sda_i};
        end
        if (qcnt != '0) begin
          qcnt <= qcnt - 1'b1;
        end else begin
          qcnt  <= Q_TOP;
          phase <= phase + 2'd1;
          if (phase != 2'd3) begin
            scl_oe <= scl_low(state, phase + 2'd1);
          end else begin
            scl_oe <= 1'b1;
            case (state)
              START: begin
                state    <= WR_BYTE;
                tx_shift <= {dev_q, 1'b0};
                bit_cnt  <= 3'd7;
                byte_sel <= 2'd0;
              end
              WR_BYTE: begin
                if (bit_cnt == 3'd0) begin
                  state <= WR_ACK;
                end else begin
                  bit_cnt  <= bit_cnt - 3'd1;
                  tx_shift <= {tx_shift[6:0], 1'b0};
                end
              end
              WR_ACK: begin
                if (nack) begin
                  state <= STOP;
                end else begin
                  case (byte_sel)
                    2'd0: begin
                      state    <= WR_BYTE;
                      tx_shift <= reg_q;
                      bit_cnt  <= 3'd7;
                      byte_sel <= 2'd1;
                    end
                    2'd1: state <= RSTART;
                    default: begin
                      state   <= RD_BYTE;
                      bit_cnt <= 3'd7;
                    end
                  endcase
                end
              end
              RSTART: begin
                state    <= WR_BYTE;
                tx_shift <= {dev_q, 1'b1};
                bit_cnt  <= 3'd7;
                byte_sel <= 2'd2;
              end
              RD_BYTE: begin
                if (bit_cnt == 3'd0)
                  state <= RD_ACK;
                else
                  bit_cnt <= bit_cnt - 3'd1;
              end
              RD_ACK: begin
                if (rd_last) begin
                  state <= STOP;
                end else begin
                  state   <= RD_BYTE;
                  rd_last <= 1'b1;
                  bit_cnt <= 3'd7;
                end
              end
              STOP: begin
                state   <= IDLE;
                scl_oe  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                ack_err <= nack;
                if (!nack)
                  data_out <= rx_shift;
              end
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: doc/i2c_sensor_reader.md
# i2c_sensor_reader

Synthesizable I2C master that performs one complete 16-bit register read from an environmental sensor: address-write, register pointer, repeated START, address-read, two data bytes, STOP. It sits between the sensor I2C pins and the feature-capture logic that feeds the MLP classifier. Each `start` request yields exactly one `done` pulse, carrying either valid data or an ACK error.

## Interface
- `CLK_DIV`, 250: `clk` cycles per SCL quarter-period (SCL = f_clk / (4·CLK_DIV)); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transaction; sampled only when `busy`=0.
- `dev_addr`  in  7  target 7-bit address; latched on an accepted `start`.
- `reg_addr`  in  8  register pointer byte; latched on an accepted `start`.
- `scl_oe`  out  1  1 = pull SCL low; 0 = release (pulled up externally).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `sda_i`  in  1  sampled SDA line level.
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle.
- `done`  out  1  one-cycle pulse at transaction end (success or abort).
- `ack_err`  out  1  valid with `done`: 1 = a slave ACK was missing; held until the next accepted `start`.
- `data_out`  out  16  MSB-first read result; updated only on successful `done`, otherwise held.

## Operation
- Reset values: `scl_oe`=0, `sda_oe`=0, `busy`=0, `done`=0, `ack_err`=0, `data_out`=0, state IDLE.
- States: IDLE → START → WR_BYTE → WR_ACK → (repeat for register byte) → RSTART → WR_BYTE(addr+R) → WR_ACK → RD_BYTE → RD_ACK → (repeat for second byte) → STOP → IDLE.
- Byte sequence: {dev_addr,0}, reg_addr, repeated START, {dev_addr,1}, data[15:8] (master ACK: `sda_oe`=1), data[7:0] (master NACK: `sda_oe`=0).
- Each bit occupies 4 quarters. Q0: SCL low, drive or release SDA. Q1: SCL low. Q2: SCL released. Q3: SCL released. SDA is sampled on the last cycle of Q2.
- START and RSTART, 4 quarters each: SDA released with SCL released, then SDA low with SCL released, then SCL low. STOP, 4 quarters: SCL low with SDA low, SCL released, then SDA released, then hold idle.
- The master releases SDA during WR_ACK bits and all RD_BYTE bits.
- NACK handling: any of the three WR_ACK samples reading `sda_i`=1 aborts. The current bit completes, the master jumps to STOP, then pulses `done` with `ack_err`=1. `data_out` is unchanged.
- The read shift register assembles 16 bits internally. `data_out` loads in the `done` cycle.
- `start` while `busy`=1 is ignored and not queued.
- Clock stretching and multi-master arbitration are not supported. SCL is never sampled.

## Timing
- Accepted `start` at edge N: `busy`=1 from N+1, and the first START quarter begins at N+1.
- A full successful read is 4 (START) + 27·4 (3 write bytes plus ACKs) + 4 (RSTART) + 18·4 (2 read bytes plus ACKs) + 4 (STOP) = 192 quarters.
- Success path: `done`=1 and `busy`=0 at edge N+1+192·CLK_DIV. `start` may be re-accepted in that same `done` cycle.
- The quarter counter counts CLK_DIV−1 down to 0. It wraps and advances the phase on 0.
- `scl_oe` and `sda_oe` are registered outputs, and they never change in the same cycle. SDA changes only while SCL is low, except in START/RSTART/STOP.
- `rst` asserted mid-transaction: at the next edge both OE outputs go to 0, state goes to IDLE, and `busy`/`done` go to 0. No STOP is generated.

## Test plan
- Slave model at 0x44 returning 0x00FA, `reg_addr`=0x00, CLK_DIV=4 → `done` at start+769 cycles, `data_out`=0x00FA, `ack_err`=0.
- `dev_addr`=0x45 with no responding slave → abort after the first ACK bit, STOP seen on the bus, `done` with `ack_err`=1, `data_out` holds the previous value.
- Slave NACKs the register byte → STOP after byte 2, `ack_err`=1, no repeated START observed.
- Bus monitor over a full read at 0x5A returning 0x0258 → decodes S, 0xB4, A, reg, A, Sr, 0xB5, A, 0x02, A(master), 0x58, N(master), P.
- `start` pulsed again while `busy` → ignored, exactly one `done`. `rst` asserted mid-RD_BYTE → next cycle `scl_oe`=`sda_oe`=0, `busy`=0, a subsequent read succeeds.
